// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time over a
// valid/ready request channel, registers the response and hands it to decode.
// A redirect resteers the PC; any fetch already in flight is squashed.
//
// state | meaning
// IDLE  | one cycle after reset release, no request yet
// REQ   | request presented, waiting for memory to accept it
// WAIT  | request accepted, waiting for the response
// FULL  | instruction held for decode, waiting for if_ready
module instr_fetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic            req_valid_q;
  logic [XLEN-1:0] req_addr_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_instr_q;
  logic [XLEN-1:0] if_pc_q;
  logic            squash_q;

  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_d;

  // Word-aligned redirect target and the PC to use when entering REQ.
  always_comb begin
    redir_tgt = redirect_pc & ~XLEN'(3);
    pc_d      = redirect_valid ? redir_tgt : pc_q;
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP;
      if_pc_q     <= '0;
      squash_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pc_q        <= pc_d;
          req_addr_q  <= pc_d;
          req_valid_q <= 1'b1;
          state_q     <= REQ;
        end
        REQ: begin
          // Request in flight keeps its old address; redirect only marks it stale.
          if (redirect_valid) begin
            pc_q     <= redir_tgt;
            squash_q <= 1'b1;
          end
          if (imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (squash_q || redirect_valid) begin
              squash_q    <= 1'b0;
              pc_q        <= pc_d;
              req_addr_q  <= pc_d;
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end else begin
              if_instr_q <= imem_rsp_data;
              if_pc_q    <= req_addr_q;
              pc_q       <= pc_q + XLEN'(4);
              if_valid_q <= 1'b1;
              state_q    <= FULL;
            end
          end else if (redirect_valid) begin
            pc_q     <= redir_tgt;
            squash_q <= 1'b1;
          end
        end
        FULL: begin
          // Redirect takes priority over a simultaneous decode handshake.
          if (redirect_valid || if_ready) begin
            pc_q        <= pc_d;
            req_addr_q  <= pc_d;
            req_valid_q <= 1'b1;
            if_valid_q  <= 1'b0;
            state_q     <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign opcode         = if_instr_q[6:0];
  assign funct3         = if_instr_q[14:12];
  assign funct7         = if_instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance with RESET_PC=0 and a
// second one with RESET_PC=0xFFFF_FFFC for address wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid, req_ready, rsp_valid, redir_valid, ifv, ifr;
  logic [31:0] req_addr, rsp_data, redir_pc, instr, ipc;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;

  logic        req_valid1, req_ready1, rsp_valid1, ifv1, ifr1;
  logic [31:0] req_addr1, rsp_data1, instr1, ipc1;
  logic [6:0]  opc1, f71;
  logic [2:0]  f31;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc),
    .if_valid(ifv), .if_ready(ifr), .if_instr(instr), .if_pc(ipc),
    .opcode(opc), .funct3(f3), .funct7(f7)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid1), .imem_req_ready(req_ready1), .imem_req_addr(req_addr1),
    .imem_rsp_valid(rsp_valid1), .imem_rsp_data(rsp_data1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(ifv1), .if_ready(ifr1), .if_instr(instr1), .if_pc(ipc1),
    .opcode(opc1), .funct3(f31), .funct7(f71)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    req_ready = 0; rsp_valid = 0; rsp_data = 0; redir_valid = 0; redir_pc = 0; ifr = 0;
    req_ready1 = 0; rsp_valid1 = 0; rsp_data1 = 0; ifr1 = 0;

    // Reset state
    tick(); tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_if_valid", 32'(ifv), 32'd0);
    chk("rst_if_instr", instr, 32'h0000_0013);
    chk("rst_if_pc", ipc, 32'h0);
    chk("rst_opcode", 32'(opc), 32'h13);

    // 1: first fetch
    rst_n = 1;
    tick();
    chk("t1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_req_addr", req_addr, 32'h0);
    chk("t1_no_ifv_req", 32'(ifv), 32'd0);
    req_ready = 1;
    tick();
    chk("t1_wait_req_valid", 32'(req_valid), 32'd0);
    req_ready = 0; rsp_valid = 1; rsp_data = 32'h0050_0093;
    tick();
    rsp_valid = 0;
    chk("t1_if_valid", 32'(ifv), 32'd1);
    chk("t1_if_instr", instr, 32'h0050_0093);
    chk("t1_opcode", 32'(opc), 32'h13);
    chk("t1_funct3", 32'(f3), 32'h0);
    chk("t1_if_pc", ipc, 32'h0);

    // 2: decode stall holds outputs
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_ifv", 32'(ifv), 32'd1);
      chk("t2_hold_instr", instr, 32'h0050_0093);
      chk("t2_hold_pc", ipc, 32'h0);
      chk("t2_no_req", 32'(req_valid), 32'd0);
    end
    ifr = 1;
    tick();
    ifr = 0;
    chk("t2_ifv_drop", 32'(ifv), 32'd0);
    chk("t2_req_valid", 32'(req_valid), 32'd1);
    chk("t2_req_addr", req_addr, 32'h4);

    // 3: redirect during WAIT squashes the response
    req_ready = 1;
    tick();
    req_ready = 0; redir_valid = 1; redir_pc = 32'h103;
    tick();
    redir_valid = 0;
    chk("t3_wait_no_req", 32'(req_valid), 32'd0);
    rsp_valid = 1; rsp_data = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 0;
    chk("t3_squash_ifv", 32'(ifv), 32'd0);
    chk("t3_req_valid", 32'(req_valid), 32'd1);
    chk("t3_req_addr", req_addr, 32'h100);
    req_ready = 1;
    tick();
    req_ready = 0; rsp_valid = 1; rsp_data = 32'h4020_8133;
    tick();
    rsp_valid = 0;
    chk("t3_if_valid", 32'(ifv), 32'd1);
    chk("t3_if_pc", ipc, 32'h100);
    chk("t3_if_instr", instr, 32'h4020_8133);
    chk("t3_opcode", 32'(opc), 32'h33);
    chk("t3_funct7", 32'(f7), 32'h20);
    ifr = 1;
    tick();
    ifr = 0;
    chk("t3_next_addr", req_addr, 32'h104);

    // 4: backpressured request with redirect in its second cycle
    tick();
    chk("t4_c1_addr", req_addr, 32'h104);
    redir_valid = 1; redir_pc = 32'h200;
    tick();
    redir_valid = 0;
    chk("t4_c2_addr", req_addr, 32'h104);
    chk("t4_c2_valid", 32'(req_valid), 32'd1);
    tick();
    chk("t4_c3_addr", req_addr, 32'h104);
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("t4_accepted", 32'(req_valid), 32'd0);
    rsp_valid = 1; rsp_data = 32'h1111_1111;
    tick();
    rsp_valid = 0;
    chk("t4_squash_ifv", 32'(ifv), 32'd0);
    chk("t4_req_valid", 32'(req_valid), 32'd1);
    chk("t4_req_addr", req_addr, 32'h200);

    // 5: redirect in FULL beats simultaneous if_ready
    req_ready = 1;
    tick();
    req_ready = 0; rsp_valid = 1; rsp_data = 32'h0000_A003;
    tick();
    rsp_valid = 0;
    chk("t5_if_pc", ipc, 32'h200);
    chk("t5_funct3", 32'(f3), 32'h2);
    chk("t5_opcode", 32'(opc), 32'h03);
    redir_valid = 1; redir_pc = 32'h40; ifr = 1;
    tick();
    redir_valid = 0; ifr = 0;
    chk("t5_ifv_drop", 32'(ifv), 32'd0);
    chk("t5_req_valid", 32'(req_valid), 32'd1);
    chk("t5_req_addr", req_addr, 32'h40);

    // 6: asynchronous reset during WAIT, stale response ignored
    req_ready = 1;
    tick();
    req_ready = 0;
    chk("t6_in_wait", 32'(req_valid), 32'd0);
    #2 rst_n = 0;
    #1;
    chk("t6_async_req_valid", 32'(req_valid), 32'd0);
    chk("t6_async_req_addr", req_addr, 32'h0);
    chk("t6_async_ifv", 32'(ifv), 32'd0);
    chk("t6_async_instr", instr, 32'h0000_0013);
    chk("t6_async_pc", ipc, 32'h0);
    rsp_valid = 1; rsp_data = 32'hBAD0_BAD0;
    tick();
    rst_n = 1;
    tick();
    chk("t6_req_valid", 32'(req_valid), 32'd1);
    chk("t6_req_addr", req_addr, 32'h0);
    chk("t6_stale_ifv", 32'(ifv), 32'd0);
    tick();
    rsp_valid = 0;
    chk("t6_stale_ifv2", 32'(ifv), 32'd0);
    chk("t6_stale_instr", instr, 32'h0000_0013);

    // 5b: PC wrap from RESET_PC = 0xFFFF_FFFC
    chk("wrap_req_valid", 32'(req_valid1), 32'd1);
    chk("wrap_first_addr", req_addr1, 32'hFFFF_FFFC);
    req_ready1 = 1;
    tick();
    req_ready1 = 0; rsp_valid1 = 1; rsp_data1 = 32'h0000_0013;
    tick();
    rsp_valid1 = 0;
    chk("wrap_if_valid", 32'(ifv1), 32'd1);
    chk("wrap_if_pc", ipc1, 32'hFFFF_FFFC);
    ifr1 = 1;
    tick();
    ifr1 = 0;
    chk("wrap_next_valid", 32'(req_valid1), 32'd1);
    chk("wrap_next_addr", req_addr1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
